// File: rtl/mem_arbiter.sv
// Shared RAM port arbiter for instruction fetch and data LW/SW, with data priority and a fetch starvation guard.
// Optional hit counters (icount/dcount) are enabled by defining MEM_ARBITER_STATS_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  input  logic        halt_in,
  output logic        halted,
  output logic        bus_error,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
`ifdef MEM_ARBITER_STATS_EN
  ,
  output logic [31:0] icount,
  output logic [31:0] dcount
`endif
);

  typedef enum logic [1:0] {IDLE, IREQ, DREQ, HALTED} state_e;

  localparam logic [1:0] RAM_ACCESS = 2'b10;
  localparam logic [1:0] RAM_ERROR  = 2'b11;
  localparam logic [3:0] LIMIT      = 4'(STARVE_LIMIT);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_q, store_d;
  logic        wr_q, wr_d;
  logic [3:0]  starve_q, starve_d;
  logic        bus_error_q, bus_error_d;
  logic        access, error, data_req;

  assign access   = (ramstate == RAM_ACCESS);
  assign error    = (ramstate == RAM_ERROR);
  assign data_req = dREN | dWEN;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    store_d     = store_q;
    wr_d        = wr_q;
    starve_d    = starve_q;
    bus_error_d = bus_error_q;
    case (state_q)
      IDLE: begin
        if (halt_in) begin
          state_d = HALTED;
        end else if (data_req && !(iREN && starve_q == LIMIT)) begin
          state_d = DREQ;
          addr_d  = daddr;
          store_d = dstore;
          wr_d    = dWEN;
        end else if (iREN) begin
          state_d = IREQ;
          addr_d  = iaddr;
          wr_d    = 1'b0;
        end
      end
      DREQ: begin
        if (access) begin
          state_d  = IDLE;
          // Count only data grants that actually made a waiting fetch wait longer.
          starve_d = !iREN ? '0 : (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
        end else if (error) begin
          state_d     = IDLE;
          bus_error_d = 1'b1;
        end
      end
      IREQ: begin
        if (access) begin
          state_d  = IDLE;
          starve_d = '0;
        end else if (error) begin
          state_d     = IDLE;
          bus_error_d = 1'b1;
        end
      end
      HALTED: state_d = HALTED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      store_q     <= '0;
      wr_q        <= 1'b0;
      starve_q    <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      store_q     <= store_d;
      wr_q        <= wr_d;
      starve_q    <= starve_d;
      bus_error_q <= bus_error_d;
    end
  end

  // A requester that dropped its request mid-access still lets RAM finish, but gets no hit.
  assign ihit      = (state_q == IREQ) && access && iREN;
  assign dhit      = (state_q == DREQ) && access && data_req;
  assign iload     = ramload;
  assign dload     = ramload;
  assign ramREN    = (state_q == IREQ) || ((state_q == DREQ) && !wr_q);
  assign ramWEN    = (state_q == DREQ) && wr_q;
  assign ramaddr   = addr_q;
  assign ramstore  = store_q;
  assign halted    = (state_q == HALTED);
  assign bus_error = bus_error_q;

`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount_q, icount_d;
  logic [31:0] dcount_q, dcount_d;

  always_comb begin
    icount_d = icount_q + {31'b0, ihit};
    dcount_d = dcount_q + {31'b0, dhit};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      icount_q <= '0;
      dcount_q <= '0;
    end else begin
      icount_q <= icount_d;
      dcount_q <= dcount_d;
    end
  end

  assign icount = icount_q;
  assign dcount = dcount_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter: a transaction-level reference model predicts
// per-cycle RAM-side outputs and hit payloads; a negedge monitor pops and compares.
module tb_mem_arbiter;

  localparam int LIMIT = 4;
  localparam logic [1:0] RS_FREE = 2'b00, RS_BUSY = 2'b01, RS_ACCESS = 2'b10, RS_ERROR = 2'b11;

  logic        CLK = 1'b0;
  logic        RST, iREN, dREN, dWEN, halt_in;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, halted, bus_error, ramREN, ramWEN;
`ifdef MEM_ARBITER_STATS_EN
  logic [31:0] icount, dcount;
`endif

  always #5 CLK = ~CLK;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
    .halt_in(halt_in), .halted(halted), .bus_error(bus_error),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
`ifdef MEM_ARBITER_STATS_EN
    , .icount(icount), .dcount(dcount)
`endif
  );

  typedef struct {
    int unsigned cyc;
    logic        is_d;
    logic [31:0] data;
  } hit_t;

  typedef struct {
    int unsigned cyc;
    logic        ren, wen, chk_addr, chk_store, halted, berr;
    logic [31:0] addr, store, icnt, dcnt;
  } cyc_t;

  hit_t exp_hit_q[$];
  cyc_t exp_cyc_q[$];
  logic grant_log[$];
  logic log_en = 1'b0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  // Reference model: who owns the RAM port (0 none, 1 fetch, 2 data) and what was latched at grant.
  int          owner;
  int          m_starve;
  logic [31:0] m_addr, m_store, m_icnt, m_dcnt;
  logic        m_wr, m_halt, m_err, m_valid = 1'b0;

  logic        i_pend = 1'b0, d_pend = 1'b0, d_wr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'($urandom_range(255)) << 2;
  endfunction

  task automatic model_step();
    cyc_t r;
    logic ih, dh;
    ih = (owner == 1) && (ramstate == RS_ACCESS) && iREN;
    dh = (owner == 2) && (ramstate == RS_ACCESS) && (dREN || dWEN);
    if (m_valid) begin
      r.cyc       = cyc;
      r.ren       = (owner == 1) || (owner == 2 && !m_wr);
      r.wen       = (owner == 2) && m_wr;
      r.chk_addr  = (owner != 0);
      r.chk_store = (owner == 2);
      r.addr      = m_addr;
      r.store     = m_store;
      r.halted    = m_halt;
      r.berr      = m_err;
      r.icnt      = m_icnt;
      r.dcnt      = m_dcnt;
      exp_cyc_q.push_back(r);
      if (ih) exp_hit_q.push_back('{cyc, 1'b0, ramload});
      if (dh) exp_hit_q.push_back('{cyc, 1'b1, ramload});
    end
    if (RST) begin
      owner = 0; m_starve = 0; m_halt = 1'b0; m_err = 1'b0;
      m_icnt = '0; m_dcnt = '0; m_addr = '0; m_store = '0; m_wr = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid && !m_halt) begin
      if (ih) m_icnt = m_icnt + 1;
      if (dh) m_dcnt = m_dcnt + 1;
      if (owner == 0) begin
        if (halt_in) m_halt = 1'b1;
        else if ((dREN || dWEN) && !(iREN && m_starve == LIMIT)) begin
          owner = 2; m_addr = daddr; m_store = dstore; m_wr = dWEN;
        end else if (iREN) begin
          owner = 1; m_addr = iaddr;
        end
      end else if (ramstate == RS_ACCESS) begin
        if (owner == 2) m_starve = iREN ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
        else m_starve = 0;
        owner = 0;
      end else if (ramstate == RS_ERROR) begin
        m_err = 1'b1;
        owner = 0;
      end
    end
    if (ih) i_pend = 1'b0;
    if (dh) d_pend = 1'b0;
  endtask

  // mode 0: both requesters always pending, RAM always ACCESS (starvation pattern); mode 1: random.
  task automatic do_cycle(input logic rst, input logic halt, input int mode);
    int unsigned r;
    @(posedge CLK);
    #1;
    RST = rst;
    halt_in = halt;
    if (!i_pend && (mode == 0 || $urandom_range(99) < 30)) begin
      i_pend = 1'b1;
      iaddr = rand_addr();
    end else if (mode == 1 && i_pend) begin
      if ($urandom_range(99) < 3) i_pend = 1'b0;
      else if ($urandom_range(99) < 10) iaddr = rand_addr();
    end
    if (!d_pend && (mode == 0 || $urandom_range(99) < 30)) begin
      d_pend = 1'b1;
      d_wr = mode == 1 && $urandom_range(1) == 1;
      daddr = rand_addr();
      dstore = $urandom;
    end else if (mode == 1 && d_pend) begin
      if ($urandom_range(99) < 3) d_pend = 1'b0;
      else if ($urandom_range(99) < 10) begin
        daddr = rand_addr();
        dstore = $urandom;
      end
    end
    iREN = i_pend;
    dWEN = d_pend && d_wr;
    dREN = d_pend && (!d_wr || $urandom_range(1) == 1);
    r = $urandom_range(99);
    if (mode == 0)   ramstate = RS_ACCESS;
    else if (r < 15) ramstate = RS_FREE;
    else if (r < 45) ramstate = RS_BUSY;
    else if (r < 90) ramstate = RS_ACCESS;
    else             ramstate = RS_ERROR;
    ramload = $urandom;
    #1;
    model_step();
    cyc++;
  endtask

  always @(negedge CLK) begin : monitor
    cyc_t r;
    hit_t h;
    logic exp_i, exp_d;
    if (exp_cyc_q.size() > 0) begin
      r = exp_cyc_q.pop_front();
      chk("ramREN", 32'(ramREN), 32'(r.ren));
      chk("ramWEN", 32'(ramWEN), 32'(r.wen));
      if (r.chk_addr)  chk("ramaddr", ramaddr, r.addr);
      if (r.chk_store) chk("ramstore", ramstore, r.store);
      chk("halted", 32'(halted), 32'(r.halted));
      chk("bus_error", 32'(bus_error), 32'(r.berr));
`ifdef MEM_ARBITER_STATS_EN
      chk("icount", icount, r.icnt);
      chk("dcount", dcount, r.dcnt);
`endif
      while (exp_hit_q.size() > 0 && exp_hit_q[0].cyc < r.cyc) begin
        void'(exp_hit_q.pop_front());
        miscompares++;
        $display("FAIL stale_hit @cycle %0d: predicted hit never matched", r.cyc);
      end
      exp_i = 1'b0;
      exp_d = 1'b0;
      h = '{0, 1'b0, '0};
      if (exp_hit_q.size() > 0 && exp_hit_q[0].cyc == r.cyc) begin
        h = exp_hit_q.pop_front();
        exp_i = !h.is_d;
        exp_d = h.is_d;
      end
      chk("ihit", 32'(ihit), 32'(exp_i));
      chk("dhit", 32'(dhit), 32'(exp_d));
      if (exp_i && ihit) chk("iload", iload, h.data);
      if (exp_d && dhit) chk("dload", dload, h.data);
      if (log_en && (ihit || dhit)) grant_log.push_back(dhit);
    end
  end

  initial begin
    logic exp_order[10];
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    RST = 1'b1; halt_in = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = RS_FREE;
    for (int ep = 0; ep < 8; ep++) begin
      int mode;
      mode = (ep == 0) ? 0 : 1;
      log_en = (ep == 0);
      repeat (2) do_cycle(1'b1, 1'b0, mode);
      repeat (400) do_cycle(mode == 1 && $urandom_range(199) == 0, 1'b0, mode);
      repeat (15) do_cycle(1'b0, 1'b1, mode);
      if (ep == 0) begin
        @(negedge CLK);
        #1;
        log_en = 1'b0;
        chk("grant_count_ge10", 32'(grant_log.size() >= 10), 32'd1);
        for (int unsigned i = 0; i < 10 && i < grant_log.size(); i++)
          chk($sformatf("grant_order[%0d]", i), 32'(grant_log[i]), 32'(exp_order[i]));
      end
    end
    repeat (2) @(negedge CLK);
    #1;
    chk("cycle_queue_drained", exp_cyc_q.size(), 32'd0);
    chk("hit_queue_drained", exp_hit_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared RAM port between the instruction-fetch requester and the data (LW/SW) requester of the MIPS datapath.
- Registered FSM: grants one transaction at a time, holds the address and store data stable to RAM until RAM reports ACCESS, and returns a one-cycle hit to the granted side.
- Data has priority; a starvation counter guarantees fetch progress.
- Honours the control path's halt request (mem_halt) once in-flight traffic drains.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before the next grant is forced to instruction; range 1..15.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous, active-high reset
- iREN  in  1  instruction read request; held until ihit
- iaddr  in  32  instruction word address
- iload  out  32  fetched instruction; valid only when ihit=1
- ihit  out  1  one-cycle instruction completion pulse
- dREN  in  1  data read request; held until dhit
- dWEN  in  1  data write request; held until dhit; wins over dREN if both are 1
- daddr  in  32  data address
- dstore  in  32  write data
- dload  out  32  read data; valid only when dhit=1
- dhit  out  1  one-cycle data completion pulse
- halt_in  in  1  halt request from control unit (mem_halt)
- halted  out  1  sticky, high once halt has taken effect
- bus_error  out  1  sticky, high once RAM has reported ERROR
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR

Behaviour:
- States: IDLE, IREQ, DREQ, HALTED.
- Reset (RST=1 at a clock edge), regardless of current state or in-flight transaction:
  - state=IDLE, starve_cnt=0, halted=0, bus_error=0.
  - All RAM strobes are 0 in the same cycle the edge takes effect. An aborted RAM access is not completed.
- IDLE:
  - ramREN=ramWEN=0, ihit=dhit=0.
  - Next state: halt_in=1 -> HALTED (halt beats pending requests). Else data request (dREN|dWEN) and not (iREN and starve_cnt==STARVE_LIMIT) -> DREQ. Else iREN -> IREQ. Else stay IDLE.
  - On entry to DREQ or IREQ, latch address, store data and rd/wr kind into internal registers.
- DREQ:
  - Drive ramaddr=latched daddr, ramstore=latched dstore, and ramWEN=1 if the latched kind is write, else ramREN=1.
  - ramstate=ACCESS: dhit=1 this cycle, dload=ramload (combinational pass-through), next IDLE.
  - starve_cnt at ACCESS: if iREN=1, starve_cnt+1 (saturating at STARVE_LIMIT); else 0.
  - ramstate=FREE or BUSY: hold state and all outputs.
  - ramstate=ERROR: no hit, bus_error<=1, next IDLE. The requester still holds its request, so it is re-arbitrated (retry).
- IREQ:
  - Drive ramREN=1 with ramaddr=latched iaddr.
  - ramstate=ACCESS: ihit=1, iload=ramload, starve_cnt<=0, next IDLE.
  - ERROR: handled as in DREQ.
- Minimum latency: request seen in IDLE at cycle 0, RAM driven from cycle 1, hit in the first cycle with ramstate=ACCESS. Back-to-back transactions have one IDLE bubble.
- Request deasserted mid-transaction: the access completes on RAM, but the hit is suppressed. A write is still performed.
- Requester address changes mid-transaction: ignored; the latched value is used.
- halt_in during IREQ/DREQ: the current transaction completes normally, then IDLE sees halt_in and goes to HALTED.
- HALTED:
  - All strobes 0, hits 0, halted=1.
  - Absorbing; only RST leaves it.
- Hits are never asserted outside the cycle of ACCESS in the matching state. ihit and dhit are never both 1.
- iload/dload are don't-care when their hit is 0; drive them from ramload.

Optional Feature:
- Macro MEM_ARBITER_STATS_EN.
- When defined: adds ports icount out 32 and dcount out 32.
  - Each counts hits delivered (ihit / dhit pulses) and wraps modulo 2^32.
  - Both cleared by RST; both frozen in HALTED.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Lone fetch: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x3C010001 -> ramREN=1, ramaddr=0x40 from cycle 1; ihit=1 and iload=0x3C010001 on cycle 3 only.
- Write priority: iREN and dWEN asserted together, daddr=0x80, dstore=0xDEADBEEF -> DREQ first, ramWEN=1 with ramstore=0xDEADBEEF; then IREQ; dhit precedes ihit.
- Starvation, STARVE_LIMIT=4: dREN and iREN held continuously, RAM always ACCESS -> grant order D,D,D,D,I,D,D,D,D,I.
- Halt drain: halt_in=1 while DREQ is waiting on BUSY -> dhit still delivered, then halted=1 and no strobes for 10 further cycles despite iREN=1.
- Error and retry: ramstate=ERROR during IREQ -> no ihit, bus_error=1 sticky; a retried fetch then completes with ihit=1.
- Reset mid-access: RST=1 during DREQ -> next cycle strobes=0, state IDLE, halted=0, bus_error=0; under MEM_ARBITER_STATS_EN, icount=dcount=0.
